// File: rtl/uart_tx_sched_pkg.sv
// Shared constants and state encoding for the UART TX scheduler.
// UART_TX_SCHED_CHKSUM_EN adds the checksum trailer state.
package uart_tx_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 8;
    localparam int LW_DEF   = 6;
    localparam int ID_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
`ifdef UART_TX_SCHED_CHKSUM_EN
        ST_CHK   = 3'd5,
`endif
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        int slot;
        slot  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            slot = (int'(ptr) + off) % NREQ;
            if (!any && req[slot]) begin
                any         = 1'b1;
                grant[slot] = 1'b1;
                idx         = ID_W'(slot);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte UART transmitter between NREQ message requesters.
// Define UART_TX_SCHED_CHKSUM_EN to append an XOR checksum trailer byte to non-empty messages.
//
// state | meaning
// IDLE  | waiting for any request; latches the arbitration winner
// GRANT | latches base/len of winner; busy rises
// FETCH | RAM read strobe at base+cnt
// WAIT  | RAM data returns and is captured into tx_data
// SEND  | tx_valid held until serializer accepts
// CHK   | loads checksum trailer into tx_data (checksum build only)
// DONE  | done pulse on winner slot; rr pointer advances
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_base,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [ID_W-1:0]   active_id,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    state_t state, state_nxt;

    logic [ID_W-1:0] winner;
    logic [NREQ-1:0] win_oh;
    logic [ID_W-1:0] rr_ptr;
    logic [AW-1:0]   base;
    logic [LW-1:0]   len;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   cnt_inc;
    logic            last_byte;
    logic [AW-1:0]   grant_base;
    logic [LW-1:0]   grant_len;

    logic [NREQ-1:0] arb_grant;
    logic [ID_W-1:0] arb_idx;
    logic            arb_any;

`ifdef UART_TX_SCHED_CHKSUM_EN
    logic [7:0] chk;
    logic       trailer;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign grant_base = req_base[int'(winner)*AW +: AW];
    assign grant_len  = req_len[int'(winner)*LW +: LW];
    assign cnt_inc    = cnt + LW'(1);
    assign last_byte  = (cnt_inc == len);

    assign busy      = (state != ST_IDLE);
    assign active_id = busy ? winner : '0;
    assign done      = (state == ST_DONE) ? win_oh : '0;
    assign mem_rd_en = (state == ST_FETCH);
    assign mem_addr  = (state == ST_FETCH) ? base + AW'(cnt) : '0;
    assign tx_valid  = (state == ST_SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = (grant_len == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_SEND;
            ST_SEND: begin
                if (tx_ready) begin
`ifdef UART_TX_SCHED_CHKSUM_EN
                    if (trailer)        state_nxt = ST_DONE;
                    else if (last_byte) state_nxt = ST_CHK;
                    else                state_nxt = ST_FETCH;
`else
                    state_nxt = last_byte ? ST_DONE : ST_FETCH;
`endif
                end
            end
`ifdef UART_TX_SCHED_CHKSUM_EN
            ST_CHK:   state_nxt = ST_SEND;
`endif
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner  <= '0;
            win_oh  <= '0;
            rr_ptr  <= '0;
            base    <= '0;
            len     <= '0;
            cnt     <= '0;
            tx_data <= '0;
`ifdef UART_TX_SCHED_CHKSUM_EN
            chk     <= '0;
            trailer <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        winner <= arb_idx;
                        win_oh <= arb_grant;
                    end
                end
                ST_GRANT: begin
                    base <= grant_base;
                    len  <= grant_len;
                    cnt  <= '0;
`ifdef UART_TX_SCHED_CHKSUM_EN
                    chk     <= '0;
                    trailer <= 1'b0;
`endif
                end
                ST_WAIT: begin
                    tx_data <= mem_rdata;
`ifdef UART_TX_SCHED_CHKSUM_EN
                    chk <= chk ^ mem_rdata;
`endif
                end
                ST_SEND: begin
                    if (tx_ready) cnt <= cnt_inc;
                end
`ifdef UART_TX_SCHED_CHKSUM_EN
                ST_CHK: begin
                    tx_data <= chk;
                    trailer <= 1'b1;
                end
`endif
                ST_DONE: begin
                    // Just-served requester drops to lowest priority next round.
                    rr_ptr <= (winner == ID_W'(NREQ-1)) ? '0 : winner + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
